// File: rtl/banco_de_registradores_param.sv
// Parametrised register bank: two operand read ports, one debug read port, one write port, sequential clear engine.
// Optional same-cycle write-to-read bypass is enabled by defining BRP_BYPASS_EN.
module banco_de_registradores_param #(
  parameter int DATA_W   = 32,
  parameter int NREGS    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1
) (
  input  logic              brp_in_clk,
  input  logic              brp_in_rst,
  input  logic              brp_in_we,
  input  logic [ADDR_W-1:0] brp_in_waddr,
  input  logic [DATA_W-1:0] brp_in_wdata,
  input  logic [ADDR_W-1:0] brp_in_raddr_a,
  output logic [DATA_W-1:0] brp_out_rdata_a,
  input  logic [ADDR_W-1:0] brp_in_raddr_b,
  output logic [DATA_W-1:0] brp_out_rdata_b,
  input  logic [ADDR_W-1:0] brp_in_dbg_addr,
  output logic [DATA_W-1:0] brp_out_dbg_data,
  input  logic              brp_in_clear,
  output logic              brp_out_busy
);

  typedef enum logic {IDLE, CLEAR} state_t;

  localparam logic [ADDR_W:0] NREGS_W  = NREGS[ADDR_W:0];
  localparam logic [ADDR_W:0] LAST_PTR = NREGS_W - 1'b1;

  state_t            state_q, state_d;
  logic [ADDR_W:0]   ptr_q, ptr_d;
  logic [DATA_W-1:0] regs [0:NREGS-1];
  logic              wr_en;

  // An address is "live" when it maps to a real, writable register.
  function automatic logic addr_live(input logic [ADDR_W-1:0] a);
    return ({1'b0, a} < NREGS_W) && !((ZERO_REG != 0) && (a == '0));
  endfunction

  assign wr_en        = (state_q == IDLE) && brp_in_we && addr_live(brp_in_waddr);
  assign brp_out_busy = (state_q == CLEAR);

  function automatic logic [DATA_W-1:0] rd_port(input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] d;
    d = '0;
    if (addr_live(a)) d = regs[a];
`ifdef BRP_BYPASS_EN
    if (wr_en && (a == brp_in_waddr)) d = brp_in_wdata;
`endif
    return d;
  endfunction

  always_comb begin
    brp_out_rdata_a  = rd_port(brp_in_raddr_a);
    brp_out_rdata_b  = rd_port(brp_in_raddr_b);
    brp_out_dbg_data = rd_port(brp_in_dbg_addr);
  end

  // Clear engine: next-state logic
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      IDLE: begin
        if (brp_in_clear) begin
          state_d = CLEAR;
          ptr_d   = '0;
        end
      end
      CLEAR: begin
        ptr_d = ptr_q + 1'b1;
        if (ptr_q == LAST_PTR) begin
          state_d = IDLE;
          ptr_d   = '0;
        end
      end
      default: begin
        state_d = IDLE;
        ptr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge brp_in_clk or posedge brp_in_rst) begin
    if (brp_in_rst) begin
      state_q <= IDLE;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
    end
  end

  // Storage: the sweep has priority; writes are only accepted in IDLE
  always_ff @(posedge brp_in_clk or posedge brp_in_rst) begin
    if (brp_in_rst) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else if (state_q == CLEAR) begin
      regs[ptr_q[ADDR_W-1:0]] <= '0;
    end else if (wr_en) begin
      regs[brp_in_waddr] <= brp_in_wdata;
    end
  end

endmodule

// File: tb/tb_banco_de_registradores_param.sv
// Directed bench for banco_de_registradores_param: default 32x32 instance and a 16-bit, 12-entry, no-zero-register instance.
module tb_banco_de_registradores_param;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        we0, clear0, busy0;
  logic [4:0]  waddr0, ra0, rb0, dbg0;
  logic [31:0] wdata0, rda0, rdb0, dbgd0;

  logic        we1, clear1, busy1;
  logic [3:0]  waddr1, ra1, rb1, dbg1;
  logic [15:0] wdata1, rda1, rdb1, dbgd1;

  int checks = 0;
  int failures = 0;
  int cnt0, cnt1, cyc;

`ifdef BRP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  banco_de_registradores_param u0 (
    .brp_in_clk(clk), .brp_in_rst(rst), .brp_in_we(we0),
    .brp_in_waddr(waddr0), .brp_in_wdata(wdata0),
    .brp_in_raddr_a(ra0), .brp_out_rdata_a(rda0),
    .brp_in_raddr_b(rb0), .brp_out_rdata_b(rdb0),
    .brp_in_dbg_addr(dbg0), .brp_out_dbg_data(dbgd0),
    .brp_in_clear(clear0), .brp_out_busy(busy0)
  );

  banco_de_registradores_param #(.DATA_W(16), .NREGS(12), .ADDR_W(4), .ZERO_REG(0)) u1 (
    .brp_in_clk(clk), .brp_in_rst(rst), .brp_in_we(we1),
    .brp_in_waddr(waddr1), .brp_in_wdata(wdata1),
    .brp_in_raddr_a(ra1), .brp_out_rdata_a(rda1),
    .brp_in_raddr_b(rb1), .brp_out_rdata_b(rdb1),
    .brp_in_dbg_addr(dbg1), .brp_out_dbg_data(dbgd1),
    .brp_in_clear(clear1), .brp_out_busy(busy1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic wr0(input logic [4:0] a, input logic [31:0] d);
    we0 = 1'b1; waddr0 = a; wdata0 = d;
    @(posedge clk); #1;
    we0 = 1'b0;
  endtask

  task automatic wr1(input logic [3:0] a, input logic [15:0] d);
    we1 = 1'b1; waddr1 = a; wdata1 = d;
    @(posedge clk); #1;
    we1 = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1;
    we0 = 0; clear0 = 0; waddr0 = 0; wdata0 = 0; ra0 = 0; rb0 = 0; dbg0 = 0;
    we1 = 0; clear1 = 0; waddr1 = 0; wdata1 = 0; ra1 = 0; rb1 = 0; dbg1 = 0;

    // Reset state
    repeat (2) @(posedge clk);
    #1; ra0 = 5; rb0 = 31; dbg0 = 0; #1;
    chk("rst_a5", rda0, 32'h0);
    chk("rst_b31", rdb0, 32'h0);
    chk("rst_dbg0", dbgd0, 32'h0);
    chk("rst_busy0", {31'b0, busy0}, 32'h0);
    chk("rst_busy1", {31'b0, busy1}, 32'h0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Write and read back
    wr0(5'd8, 32'hDEADBEEF);
    wr0(5'd31, 32'h12345678);
    ra0 = 8; rb0 = 31; dbg0 = 8; #1;
    chk("wr_a8", rda0, 32'hDEADBEEF);
    chk("wr_b31", rdb0, 32'h12345678);
    chk("wr_dbg8", dbgd0, 32'hDEADBEEF);

    // Zero register hardwired vs ordinary
    wr0(5'd0, 32'hFFFFFFFF);
    wr1(4'd0, 16'hFFFF);
    ra0 = 0; ra1 = 0; #1;
    chk("zero_reg_on", rda0, 32'h0);
    chk("zero_reg_off", {16'h0, rda1}, 32'h0000FFFF);

    // Small instance: out-of-range write dropped, top register valid
    wr1(4'd13, 16'hBEEF);
    wr1(4'd11, 16'h1234);
    ra1 = 13; rb1 = 11; dbg1 = 11; #1;
    chk("oor_a13", {16'h0, rda1}, 32'h0);
    chk("top_b11", {16'h0, rdb1}, 32'h00001234);
    chk("top_dbg11", {16'h0, dbgd1}, 32'h00001234);

    // Bypass behaviour
    wr0(5'd9, 32'h1);
    we0 = 1'b1; waddr0 = 9; wdata0 = 32'hA5A5A5A5; ra0 = 9; dbg0 = 9; #1;
    chk("byp_a9", rda0, BYP ? 32'hA5A5A5A5 : 32'h1);
    chk("byp_dbg9", dbgd0, BYP ? 32'hA5A5A5A5 : 32'h1);
    @(posedge clk); #1;
    we0 = 1'b0; #1;
    chk("post_edge_a9", rda0, 32'hA5A5A5A5);
    we0 = 1'b1; waddr0 = 0; wdata0 = 32'hFFFFFFFF; ra0 = 0; #1;
    chk("byp_drop_r0", rda0, 32'h0);
    we0 = 1'b0;
    @(posedge clk); #1;

    // Sequential clear
    for (int i = 1; i < 32; i++) wr0(i[4:0], i);
    ra0 = 20; #1;
    chk("fill_a20", rda0, 32'd20);
    clear0 = 1'b1; clear1 = 1'b1;
    @(posedge clk); #1;
    clear0 = 1'b0; clear1 = 1'b0;
    cnt0 = 0; cnt1 = 0; cyc = 0;
    while ((busy0 || busy1) && cyc < 100) begin
      if (busy0) cnt0++;
      if (busy1) cnt1++;
      if (cyc == 4) begin we0 = 1'b1; waddr0 = 3; wdata0 = 32'h55; end
      if (cyc == 5) clear0 = 1'b1;
      if (cyc == 7) begin we0 = 1'b0; clear0 = 1'b0; end
      if (cyc == 10) begin
        ra0 = 5; rb0 = 20; #1;
        chk("mid_clear_a5", rda0, 32'h0);
        chk("mid_clear_b20", rdb0, 32'd20);
      end
      cyc++;
      @(posedge clk); #1;
    end
    chk("busy_cycles0", cnt0, 32'd32);
    chk("busy_cycles1", cnt1, 32'd12);
    ra0 = 3; rb0 = 31; dbg0 = 20; ra1 = 11; #1;
    chk("post_clear_a3", rda0, 32'h0);
    chk("post_clear_b31", rdb0, 32'h0);
    chk("post_clear_dbg20", dbgd0, 32'h0);
    chk("post_clear_u1_11", {16'h0, rda1}, 32'h0);

    // Reset mid-clear
    wr0(5'd30, 32'h30);
    wr0(5'd2, 32'h2);
    clear0 = 1'b1;
    @(posedge clk); #1;
    clear0 = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("pre_abort_busy", {31'b0, busy0}, 32'h1);
    rst = 1'b1; ra0 = 30; #1;
    chk("abort_busy", {31'b0, busy0}, 32'h0);
    chk("abort_a30", rda0, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;
    wr0(5'd2, 32'h22);
    ra0 = 2; rb0 = 30; #1;
    chk("after_rst_a2", rda0, 32'h22);
    chk("after_rst_b30", rdb0, 32'h0);
    chk("after_rst_busy", {31'b0, busy0}, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
